// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// IMEM_LOADER_CHECKSUM_EN adds the checksum states to the state encoding.
package imem_loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int CSUM_W         = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK_LO,
    S_CHK_HI,
`endif
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_csum.sv
// Running 16-bit word sum of the loaded program and its comparison against
// the trailing checksum; only used when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_csum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_add_en,
  input  logic [CSUM_W-1:0] i_add_data,
  input  logic [CSUM_W-1:0] i_cmp_data,
  output logic              o_match
);

  logic [CSUM_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= r_acc + i_add_data;
    end
  end

  assign o_match = (r_acc == i_cmp_data);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the fetch-stage imem write port.
// Optional trailing checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              write_enable_fm,
  output logic [ADDR_W-1:0] write_addr_fm,
  output logic [DATA_W-1:0] write_data_fm,
  output logic              rst_fm,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W:0] MAX_L = (LEN_W + 1)'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_LAST = S_CHK_LO;
`else
  localparam state_t S_AFTER_LAST = S_DONE;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          r_lo;
  logic [LEN_W-1:0]    r_cnt;
  logic                w_xfer;
  logic                w_idle_like;
  logic                w_start_ok;
  logic                w_csum_ok;
  logic [WORD_W-1:0]   w_hi_lo;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_start_ok  = start && w_idle_like;
  assign w_xfer      = in_valid && in_ready;
  assign w_hi_lo     = {in_byte, r_lo};

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK_LO, S_CHK_HI:                       in_ready = 1'b1;
`endif
      default:                                  in_ready = 1'b0;
    endcase
  end

  assign write_enable_fm = (r_state == S_WRITE);
  assign rst_fm          = !w_idle_like;
  assign cpu_hold        = !w_idle_like;
  assign done            = (r_state == S_DONE);
  assign error           = (r_state == S_ERROR);
  assign write_addr_fm   = r_addr;
  assign write_data_fm   = r_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
  imem_loader_csum u_csum (
    .clk        (clk),
    .rst_n      (reset),
    .i_clr      (w_start_ok),
    .i_add_en   (r_state == S_WRITE),
    .i_add_data (r_data),
    .i_cmp_data (w_hi_lo),
    .o_match    (w_csum_ok)
  );
`else
  assign w_csum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_xfer) w_next = S_LEN_HI;
      S_LEN_HI:
        if (w_xfer) begin
          if (w_hi_lo == '0)                w_next = S_AFTER_LAST;
          else if ({1'b0, w_hi_lo} > MAX_L) w_next = S_ERROR;
          else                              w_next = S_DATA_LO;
        end
      S_DATA_LO: if (w_xfer) w_next = S_DATA_HI;
      S_DATA_HI: if (w_xfer) w_next = S_WRITE;
      // r_cnt still holds the pre-decrement count during WRITE
      S_WRITE:   w_next = (r_cnt == LEN_W'(1)) ? S_AFTER_LAST : S_DATA_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK_LO:  if (w_xfer) w_next = S_CHK_HI;
      S_CHK_HI:  if (w_xfer) w_next = w_csum_ok ? S_DONE : S_ERROR;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= BASE_ADDR;
      r_data <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr <= BASE_ADDR;
        r_cnt  <= '0;
      end
      if (w_xfer && (r_state == S_LEN_LO || r_state == S_DATA_LO
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || r_state == S_CHK_LO
`endif
                    )) begin
        r_lo <= in_byte;
      end
      if (w_xfer && r_state == S_LEN_HI) r_cnt  <= w_hi_lo;
      if (w_xfer && r_state == S_DATA_HI) r_data <= w_hi_lo;
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt - LEN_W'(1);
      end
    end
  end

  // Checksum acceptance is unused when the feature is compiled out
  logic w_unused;
  assign w_unused = w_csum_ok;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios are
// added when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        write_enable_fm;
  logic [31:0] write_addr_fm;
  logic [15:0] write_data_fm;
  logic        rst_fm;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [31:0] wa[$];
  logic [15:0] wd[$];
  int          rdy_bad = 0;
  int          we_long = 0;
  logic        prev_we = 1'b0;

  imem_loader #(.ADDR_W(32), .DATA_W(16), .BASE_ADDR(32'h0), .MAX_WORDS(1024)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_valid        (in_valid),
    .in_byte         (in_byte),
    .in_ready        (in_ready),
    .write_enable_fm (write_enable_fm),
    .write_addr_fm   (write_addr_fm),
    .write_data_fm   (write_data_fm),
    .rst_fm          (rst_fm),
    .cpu_hold        (cpu_hold),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable_fm) begin
      wa.push_back(write_addr_fm);
      wd.push_back(write_data_fm);
      if (in_ready) rdy_bad++;
      if (prev_we) we_long++;
    end
    prev_we = write_enable_fm;
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    rdy_bad = 0;
    we_long = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    in_byte  = 8'hEE;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1 for byte %02h", in_ready, b);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_end_timeout: done=%0b error=%0b required one of them 1", done, error);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic send_csum(input logic [15:0] v, input int gap);
    send_byte(v[7:0], gap);
    send_byte(v[15:8], gap);
  endtask
`endif

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (in_ready !== 1'b0)          begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    checks++; if (write_enable_fm !== 1'b0)   begin errors++; $display("FAIL rst_we: got %0b want 0", write_enable_fm); end
    checks++; if (write_addr_fm !== 32'h0)    begin errors++; $display("FAIL rst_addr: got %h want 0", write_addr_fm); end
    checks++; if (write_data_fm !== 16'h0)    begin errors++; $display("FAIL rst_data: got %h want 0", write_data_fm); end
    checks++; if (rst_fm !== 1'b0)            begin errors++; $display("FAIL rst_rst_fm: got %0b want 0", rst_fm); end
    checks++; if (cpu_hold !== 1'b0)          begin errors++; $display("FAIL rst_cpu_hold: got %0b want 0", cpu_hold); end
    checks++; if (done !== 1'b0)              begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
    checks++; if (error !== 1'b0)             begin errors++; $display("FAIL rst_error: got %0b want 0", error); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_two_words();
    clear_log();
    pulse_start();
    checks++; if (rst_fm !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL busy_hold: rst_fm=%0b cpu_hold=%0b want 1 1", rst_fm, cpu_hold); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_ready: got %0b want 1", in_ready); end
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'hCD, 0); send_byte(8'hAB, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(16'hBE01, 0);
`endif
    wait_end();
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL two_count: got %0d writes want 2", wa.size()); end
    if (wa.size() == 2) begin
      checks++; if (wa[0] !== 32'd0 || wd[0] !== 16'h1234) begin errors++; $display("FAIL two_w0: got %h/%h want 0/1234", wa[0], wd[0]); end
      checks++; if (wa[1] !== 32'd1 || wd[1] !== 16'hABCD) begin errors++; $display("FAIL two_w1: got %h/%h want 1/abcd", wa[1], wd[1]); end
    end
    checks++; if (we_long !== 0) begin errors++; $display("FAIL two_we_width: got %0d long pulses want 0", we_long); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL two_done: done=%0b error=%0b want 1 0", done, error); end
    checks++; if (cpu_hold !== 1'b0 || rst_fm !== 1'b0) begin errors++; $display("FAIL two_release: cpu_hold=%0b rst_fm=%0b want 0 0", cpu_hold, rst_fm); end
    checks++; if (write_addr_fm !== 32'd2) begin errors++; $display("FAIL two_addr_after: got %h want 2", write_addr_fm); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_done_ready: got %0b want 0", in_ready); end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_cleared: got %0b want 0", done); end
    send_byte(8'h00, 0); send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(16'h0000, 0);
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b want 1", done); end
    repeat (3) tick();
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_len_error();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    checks++; if (error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL len_err: error=%0b done=%0b want 1 0", error, done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len_err_ready: got %0b want 0", in_ready); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL len_err_hold: got %0b want 0", cpu_hold); end
    repeat (3) tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %0b want 1", error); end
    checks++; if (wa.size() !== 0) begin errors++; $display("FAIL len_err_writes: got %0d want 0", wa.size()); end
    pulse_start();
    checks++; if (error !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL len_err_clear: error=%0b cpu_hold=%0b want 0 1", error, cpu_hold); end
    send_byte(8'h00, 0); send_byte(8'h04, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(16'h0000, 0);
`endif
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL len_max_ok: done=%0b error=%0b want 0 0", done, error); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_gaps(input int random_gaps);
    logic [7:0] bytes [0:7];
    clear_log();
    bytes = '{8'h03, 8'h00, 8'hEF, 8'hBE, 8'h02, 8'h01, 8'h00, 8'h80};
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], random_gaps ? int'($urandom_range(0, 3)) : 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(16'h3FF1, random_gaps);
`endif
    wait_end();
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL gaps%0d_count: got %0d want 3", random_gaps, wa.size()); end
    if (wa.size() == 3) begin
      checks++; if (wa[0] !== 32'd0 || wd[0] !== 16'hBEEF) begin errors++; $display("FAIL gaps%0d_w0: got %h/%h want 0/beef", random_gaps, wa[0], wd[0]); end
      checks++; if (wa[1] !== 32'd1 || wd[1] !== 16'h0102) begin errors++; $display("FAIL gaps%0d_w1: got %h/%h want 1/0102", random_gaps, wa[1], wd[1]); end
      checks++; if (wa[2] !== 32'd2 || wd[2] !== 16'h8000) begin errors++; $display("FAIL gaps%0d_w2: got %h/%h want 2/8000", random_gaps, wa[2], wd[2]); end
    end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL gaps%0d_ready_in_write: got %0d want 0", random_gaps, rdy_bad); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gaps%0d_done: got %0b want 1", random_gaps, done); end
  endtask

  task automatic test_mid_reset();
    clear_log();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'hCD, 0);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || write_enable_fm !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: in_ready=%0b we=%0b want 0 0", in_ready, write_enable_fm); end
    checks++; if (write_addr_fm !== 32'h0 || write_data_fm !== 16'h0) begin errors++; $display("FAIL mid_rst_port: addr=%h data=%h want 0 0", write_addr_fm, write_data_fm); end
    checks++; if (rst_fm !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL mid_rst_status: rst_fm=%0b hold=%0b done=%0b error=%0b want 0 0 0 0", rst_fm, cpu_hold, done, error);
    end
    tick();
    reset = 1'b1;
    in_valid = 1'b1; in_byte = 8'hAB;
    repeat (4) tick();
    in_valid = 1'b0;
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL mid_rst_writes: got %0d want 1", wa.size()); end
    clear_log();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(16'h6655, 0);
`endif
    wait_end();
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL mid_rst_reload_count: got %0d want 1", wa.size()); end
    if (wa.size() == 1) begin
      checks++; if (wa[0] !== 32'd0 || wd[0] !== 16'h6655) begin errors++; $display("FAIL mid_rst_reload: got %h/%h want 0/6655", wa[0], wd[0]); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_csum(16'h0000, 0);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL csum_match: done=%0b error=%0b want 1 0", done, error); end
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_csum(16'h0001, 0);
    checks++; if (done !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL csum_mismatch: done=%0b error=%0b want 0 1", done, error); end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    #1;
    test_reset();
    test_two_words();
    test_zero_len();
    test_len_error();
    test_gaps(0);
    test_gaps(1);
    test_mid_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that drives the fetch stage's instruction-memory write port: write_enable_fm, write_addr_fm, write_data_fm and rst_fm.
- Accepts a byte stream using a valid/ready handshake. The stream carries a length header followed by 16-bit words.
- Writes each assembled word to consecutive addresses.
- Holds the processor in reset for the whole load and releases it on completion.

Parameters:
- ADDR_W, 32, width of write_addr_fm
- DATA_W, 16, instruction word width; fixed at 16 (two bytes per word)
- BASE_ADDR, 0, address of the first written word
- MAX_WORDS, 1024, largest legal length header

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when the block is in IDLE, DONE or ERROR
- in_valid  in  1  in_byte is valid
- in_byte  in  8  stream byte
- in_ready  out  1  loader accepts in_byte this cycle
- write_enable_fm  out  1  imem write strobe
- write_addr_fm  out  ADDR_W  imem write address
- write_data_fm  out  16  imem write data
- rst_fm  out  1  fetch/PC reset; high while busy
- cpu_hold  out  1  processor reset; high while busy
- done  out  1  load completed successfully; sticky until next start
- error  out  1  load aborted; sticky until next start

Behaviour:
- Reset (reset=0, asynchronous) applies at any time, including mid-load:
  - state=IDLE
  - in_ready=0, write_enable_fm=0
  - write_addr_fm=BASE_ADDR, write_data_fm=0
  - rst_fm=0, cpu_hold=0, done=0, error=0
  - word counter and byte latch cleared
- A byte transfers on a clk edge where in_valid && in_ready. in_byte is ignored otherwise.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, (CHK_LO, CHK_HI when CHECKSUM_EN is defined), DONE, ERROR.
- IDLE/DONE/ERROR --start--> LEN_LO:
  - clear done and error
  - write_addr_fm=BASE_ADDR
  - rst_fm=1, cpu_hold=1
- start is ignored in every other state.
- LEN_LO --xfer--> LEN_HI. LEN = {hi, lo}, little-endian.
- LEN_HI --xfer--> next state depends on LEN:
  - LEN=0 → DONE
  - LEN>MAX_WORDS → ERROR
  - otherwise → DATA_LO
- DATA_LO --xfer--> DATA_HI (low byte latched).
- DATA_HI --xfer--> WRITE, with write_data_fm={byte, latched low}.
- WRITE lasts exactly one cycle:
  - write_enable_fm=1, in_ready=0
  - next cycle: write_addr_fm += 1 and remaining count -= 1
  - then → DATA_LO if count remains, otherwise → DONE (or CHK_LO when CHECKSUM_EN)
- in_ready=1 only in LEN_*, DATA_* and CHK_* states.
- Throughput: at most one word per 3 cycles.
- write_enable_fm is never high outside WRITE.
- write_addr_fm wraps modulo 2^ADDR_W; no error is raised on wrap.
- DONE and ERROR: rst_fm=0, cpu_hold=0, in_ready=0.
  - done=1 in DONE; error=1 in ERROR.
  - Both states are held until start.
- Stalled stream (in_valid low): state holds indefinitely; no timeout.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 16-bit accumulator is cleared at start and adds each word's write_data_fm in WRITE, modulo 2^16.
  - After the last word, the block reads a 2-byte little-endian checksum in CHK_LO and CHK_HI.
  - Match → DONE; mismatch → ERROR.
  - LEN=0 also reads a checksum, and the expected value is 0.
- Undefined: no CHK states; the block goes to DONE immediately after the last WRITE.

Decomposition:
- Package imem_loader_pkg:
  - state enum
  - LEN_BYTES=2, BYTES_PER_WORD=2
  - checksum width constant
- One optional sub-module, imem_loader_csum (accumulate and compare). It is instantiated only under IMEM_LOADER_CHECKSUM_EN.
- Word assembly and the FSM stay in the top module.

Test Plan:
- Reset, then start. Send 02 00 34 12 CD AB with in_valid held high. Expected:
  - write_addr_fm=0 with write_data_fm=0x1234, then write_addr_fm=1 with write_data_fm=0xABCD
  - write_enable_fm high for exactly 1 cycle per word
  - done=1, cpu_hold=0 afterwards
- Start, then send 00 00. Expected: no write pulses; DONE is reached 2 transfers after start; done=1.
- Start, then send 01 04 (LEN=1025 > 1024). Expected: error=1, in_ready=0, no write; a new start clears error.
- Load 3 words while toggling in_valid randomly. Expected: write data, addresses and order are identical to the gap-free run; in_ready=0 during each WRITE cycle.
- Drive reset low after the first word has been written (mid-second word). Expected on the same edge:
  - all outputs at their reset values
  - no further write pulses
  - the next start restarts at BASE_ADDR
- With CHECKSUM_EN, send words 0x0001 and 0xFFFF. Expected: checksum 0x0000 → done=1; checksum 0x0001 → error=1.
